// File: rtl/rv32i_types.sv
// Shared types for the memory-side arbiter.
// Contents:
//   LINE_WIDTH  - default cache line width in bits
//   WAIT_WIDTH  - width of the per-side starvation counters
//   arb_state_t - arbiter FSM states
//   grant_t     - which requester owns (or last owned) physical memory
package rv32i_types;

  localparam int LINE_WIDTH = 256;
  localparam int WAIT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Two-requester arbiter in front of a single physical memory port.
// The instruction cache (line fills only) and the data cache (fills and
// write-backs) share pmem. Ties are broken round-robin. The pmem command
// is registered at grant time and is held unchanged until pmem_resp.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   i_read, i_address               - I-cache fill request
//   i_rdata, i_resp                 - I-cache fill data / completion
//   d_read, d_write, d_address      - D-cache fill / write-back request
//   d_wdata                         - D-cache write-back data
//   d_rdata, d_resp                 - D-cache fill data / completion
//   pmem_read, pmem_write           - physical memory command
//   pmem_address, pmem_wdata        - physical memory address / write data
//   pmem_rdata, pmem_resp           - physical memory read data / completion
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = rv32i_types::LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);
  import rv32i_types::*;

  arb_state_t            state_q, state_d;
  grant_t                last_grant_q;
  logic                  block_q;      // high for the single cycle after a completion
  logic                  cmd_read_q, cmd_write_q;
  logic [ADDR_WIDTH-1:0] cmd_address_q;
  logic [LINE_WIDTH-1:0] cmd_wdata_q;
  logic [WAIT_WIDTH-1:0] wait_i_q, wait_d_q;

  logic i_req, d_req, grant_i, grant_d, done;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // A request is only considered in IDLE, and not in the cycle right after a
  // completion: the requester is still dropping its line then. On a tie the
  // side that did not win last time goes first.
  assign grant_i = (state_q == ST_IDLE) && !block_q && i_req &&
                   (!d_req || last_grant_q == GRANT_D);
  assign grant_d = (state_q == ST_IDLE) && !block_q && d_req &&
                   (!i_req || last_grant_q == GRANT_I);
  assign done    = (state_q != ST_IDLE) && pmem_resp;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_i)      state_d = ST_SERVE_I;
        else if (grant_d) state_d = ST_SERVE_D;
      end
      ST_SERVE_I, ST_SERVE_D: if (pmem_resp) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command registers, round-robin pointer, block flag and wait counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q  <= GRANT_D;
      block_q       <= 1'b0;
      cmd_read_q    <= 1'b0;
      cmd_write_q   <= 1'b0;
      cmd_address_q <= '0;
      cmd_wdata_q   <= '0;
      wait_i_q      <= '0;
      wait_d_q      <= '0;
    end else begin
      block_q <= done;
      if (grant_i) begin
        last_grant_q  <= GRANT_I;
        cmd_read_q    <= 1'b1;
        cmd_write_q   <= 1'b0;
        cmd_address_q <= i_address;
        cmd_wdata_q   <= '0;
      end else if (grant_d) begin
        // A simultaneous d_read/d_write is treated as a write-back so the two
        // pmem strobes can never be high together.
        last_grant_q  <= GRANT_D;
        cmd_read_q    <= !d_write;
        cmd_write_q   <= d_write;
        cmd_address_q <= d_address;
        cmd_wdata_q   <= d_write ? d_wdata : '0;
      end else if (done) begin
        // Clearing on completion keeps the pmem bus at zero while idle.
        cmd_read_q    <= 1'b0;
        cmd_write_q   <= 1'b0;
        cmd_address_q <= '0;
        cmd_wdata_q   <= '0;
      end

      // Starvation counters: count cycles a side waits while not owning pmem.
      if (grant_i)
        wait_i_q <= '0;
      else if (i_req && state_q != ST_SERVE_I && wait_i_q != '1)
        wait_i_q <= wait_i_q + 1'b1;

      if (grant_d)
        wait_d_q <= '0;
      else if (d_req && state_q != ST_SERVE_D && wait_d_q != '1)
        wait_d_q <= wait_d_q + 1'b1;
    end
  end

  // Outputs. Reset masks everything so nothing leaks in the cycle reset is
  // first seen, before the registers have cleared.
  always_comb begin
    i_resp       = !reset && (state_q == ST_SERVE_I) && pmem_resp;
    d_resp       = !reset && (state_q == ST_SERVE_D) && pmem_resp;
    pmem_read    = !reset && cmd_read_q;
    pmem_write   = !reset && cmd_write_q;
    pmem_address = reset ? '0 : cmd_address_q;
    pmem_wdata   = reset ? '0 : cmd_wdata_q;
  end

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk;
  logic          reset;
  logic          i_read, d_read, d_write;
  logic [AW-1:0] i_address, d_address, pmem_address;
  logic [LW-1:0] i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;
  logic          i_resp, d_resp, pmem_read, pmem_write, pmem_resp;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns pmem (0 none, 1 I, 2 D), who won
  // last, whether we are in the post-completion cycle, and the command
  // captured at grant time.
  int            m_owner = 0;
  int            m_last  = 2;
  bit            m_block = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  bit            m_wr    = 1'b0;
  logic [LW-1:0] m_wdata = '0;

  int i_pulses = 0, d_pulses = 0, adj_viol = 0;
  bit i_resp_s = 1'b0, d_resp_s = 1'b0, prev_done = 1'b0;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_next();
    int pick;
    if (reset) begin
      m_owner = 0; m_last = 2; m_block = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    end else if (m_owner != 0) begin
      if (pmem_resp) begin
        m_owner = 0; m_block = 1'b1;
      end
    end else if (m_block) begin
      m_block = 1'b0;
    end else begin
      pick = 0;
      if (i_read && (d_read || d_write)) pick = (m_last == 2) ? 1 : 2;
      else if (i_read)                   pick = 1;
      else if (d_read || d_write)        pick = 2;
      if (pick != 0) begin
        m_owner = pick;
        m_last  = pick;
        m_addr  = (pick == 1) ? i_address : d_address;
        m_wr    = (pick == 2) && d_write;
        m_wdata = m_wr ? d_wdata : '0;
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model, then return
  // just after the next rising edge where callers change inputs.
  task automatic cycle();
    logic cmd_now;
    bit   live;
    @(negedge clk);
    live    = !reset;
    cmd_now = pmem_read | pmem_write;
    check("pmem_read",  pmem_read,  live && (m_owner == 1 || (m_owner == 2 && !m_wr)));
    check("pmem_write", pmem_write, live && m_owner == 2 && m_wr);
    check("pmem_addr",  pmem_address, (live && m_owner != 0) ? m_addr : '0);
    check("pmem_wdata", pmem_wdata, (live && m_owner == 2) ? m_wdata : '0);
    check("i_resp", i_resp, live && m_owner == 1 && pmem_resp);
    check("d_resp", d_resp, live && m_owner == 2 && pmem_resp);
    check("i_rdata", i_rdata, pmem_rdata);
    check("d_rdata", d_rdata, pmem_rdata);
    if (i_resp === 1'b1) i_pulses++;
    if (d_resp === 1'b1) d_pulses++;
    i_resp_s = (i_resp === 1'b1);
    d_resp_s = (d_resp === 1'b1);
    if (prev_done && cmd_now) adj_viol++;
    prev_done = cmd_now && pmem_resp;
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  // Wait (bounded) for a pmem command, let it sit lat cycles, then complete
  // it. Reports which side got the resp; optionally drops that side's request.
  task automatic mem_respond(input int lat, input bit drop, output int side);
    int k = 0;
    side = 0;
    while (!(pmem_read || pmem_write) && k < 8) begin
      cycle();
      k++;
    end
    check("cmd_seen", pmem_read | pmem_write, 1'b1);
    if (!(pmem_read || pmem_write)) return;
    repeat (lat) cycle();
    pmem_rdata = rand_line();
    pmem_resp  = 1'b1;
    #1;
    side = i_resp ? 1 : (d_resp ? 2 : 0);
    cycle();
    pmem_resp = 1'b0;
    if (drop && side == 1) i_read = 1'b0;
    if (drop && side == 2) begin d_read = 1'b0; d_write = 1'b0; end
  endtask

  initial begin
    int            side;
    int            sides[4];
    logic [LW-1:0] pat_a, wd;
    int            i_gap, d_gap, mem_cnt;
    bit            mem_busy;

    reset = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;

    // Reset with a request pending: outputs must stay quiet.
    i_read = 1'b1; i_address = 32'h40;
    cycle();
    cycle();
    i_read = 1'b0;

    // I-only fill, memory answers on the fifth command cycle.
    do_reset();
    i_pulses = 0; d_pulses = 0;
    i_read = 1'b1; i_address = 32'h0000_0060;
    cycle();
    check("ionly_cmd_read", pmem_read, 1'b1);
    check("ionly_cmd_addr", pmem_address, 32'h60);
    repeat (4) cycle();
    pat_a = rand_line();
    pmem_rdata = pat_a; pmem_resp = 1'b1;
    #1;
    check("ionly_rdata", i_rdata, pat_a);
    check("ionly_resp", i_resp, 1'b1);
    cycle();
    pmem_resp = 1'b0; i_read = 1'b0;
    repeat (2) cycle();
    check("ionly_i_pulses", i_pulses, 1);
    check("ionly_d_pulses", d_pulses, 0);

    // Simultaneous after reset: I wins first tie, D write follows the block cycle.
    do_reset();
    wd = rand_line();
    i_read = 1'b1; i_address = 32'h80;
    d_write = 1'b1; d_address = 32'h100; d_wdata = wd;
    mem_respond(2, 1'b1, side);
    check("tie_first_side", side, 1);
    check("block_cycle_idle", pmem_read | pmem_write, 1'b0);
    cycle();
    cycle();
    check("tie_d_write", pmem_write, 1'b1);
    check("tie_d_wdata", pmem_wdata, wd);
    check("tie_d_addr", pmem_address, 32'h100);
    mem_respond(1, 1'b1, side);
    check("tie_second_side", side, 2);

    // Both sides held high: grants alternate, always with an idle gap.
    do_reset();
    adj_viol = 0;
    i_read = 1'b1; i_address = 32'h1000; d_read = 1'b1; d_address = 32'h2000;
    for (int t = 0; t < 4; t++) mem_respond($urandom_range(3, 0), 1'b0, sides[t]);
    for (int t = 0; t < 4; t++) check("rr_order", sides[t], (t % 2 == 0) ? 1 : 2);
    i_read = 1'b0; d_read = 1'b0;
    cycle();
    check("rr_adjacent", adj_viol, 0);

    // Reset two cycles into a write-back aborts it.
    do_reset();
    d_pulses = 0;
    d_write = 1'b1; d_address = 32'h140; d_wdata = rand_line();
    cycle();
    cycle();
    check("abort_write_on", pmem_write, 1'b1);
    reset = 1'b1; pmem_resp = 1'b1;
    #1;
    check("abort_no_dresp", d_resp, 1'b0);
    cycle();
    reset = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    check("abort_write_low", pmem_write, 1'b0);
    cycle();
    check("abort_d_pulses", d_pulses, 0);

    // Address churn during SERVE_D does not reach pmem.
    do_reset();
    d_read = 1'b1; d_address = 32'h200;
    cycle();
    d_address = 32'h300; d_wdata = rand_line();
    repeat (3) begin
      cycle();
      check("churn_addr", pmem_address, 32'h200);
    end
    mem_respond(0, 1'b1, side);
    check("churn_side", side, 2);

    // Spurious pmem_resp while idle.
    do_reset();
    i_pulses = 0; d_pulses = 0;
    pmem_resp = 1'b1;
    repeat (3) cycle();
    pmem_resp = 1'b0;
    check("spurious_i", i_pulses, 0);
    check("spurious_d", d_pulses, 0);

    // Randomized traffic, memory latency, churn, stray responses and resets.
    do_reset();
    i_gap = 0; d_gap = 0; mem_cnt = 0; mem_busy = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 250 == 0) begin
        reset = 1'b1; mem_busy = 1'b0;
      end else begin
        reset = 1'b0;
      end

      if (i_resp_s) begin
        if ($urandom % 4 != 0) begin i_read = 1'b0; i_gap = $urandom_range(3, 0); end
      end else if (!i_read) begin
        if (i_gap > 0) i_gap--;
        else if ($urandom % 3 == 0) begin
          i_read = 1'b1; i_address = $urandom & 32'hFFFF_FFE0;
        end
      end

      if (d_resp_s) begin
        if ($urandom % 4 != 0) begin
          d_read = 1'b0; d_write = 1'b0; d_gap = $urandom_range(3, 0);
        end
      end else if (!(d_read || d_write)) begin
        if (d_gap > 0) d_gap--;
        else if ($urandom % 3 == 0) begin
          if ($urandom % 2 == 0) d_read = 1'b1; else d_write = 1'b1;
          d_address = $urandom & 32'hFFFF_FFE0; d_wdata = rand_line();
        end
      end else if ($urandom % 4 == 0) begin
        d_address = $urandom & 32'hFFFF_FFE0; d_wdata = rand_line();
      end

      if (pmem_read || pmem_write) begin
        if (!mem_busy) begin mem_busy = 1'b1; mem_cnt = $urandom_range(4, 0); end
        if (mem_cnt == 0) begin pmem_resp = 1'b1; mem_busy = 1'b0; end
        else begin pmem_resp = 1'b0; mem_cnt--; end
      end else begin
        mem_busy = 1'b0;
        pmem_resp = ($urandom % 10 == 0);
      end
      pmem_rdata = rand_line();
      cycle();
    end
    reset = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: physical byte address width on all ports.
REQ-002 SHALL have parameter LINE_WIDTH, default 256: cache line width in bits on all data buses.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- i_read  in  1  instruction cache line-fill request.
- i_address  in  ADDR_WIDTH  instruction cache line address.
- i_rdata  out  LINE_WIDTH  fill data to the instruction cache.
- i_resp  out  1  instruction transaction complete.
- d_read  in  1  data cache line-fill request.
- d_write  in  1  data cache write-back request.
- d_address  in  ADDR_WIDTH  data cache line address.
- d_wdata  in  LINE_WIDTH  write-back data.
- d_rdata  out  LINE_WIDTH  fill data to the data cache.
- d_resp  out  1  data transaction complete.
- pmem_read  out  1  physical memory read.
- pmem_write  out  1  physical memory write.
- pmem_address  out  ADDR_WIDTH  physical memory address.
- pmem_wdata  out  LINE_WIDTH  physical memory write data.
- pmem_rdata  in  LINE_WIDTH  physical memory read data.
- pmem_resp  in  1  physical memory transaction complete.

Function
REQ-004 SHALL implement a three-state FSM: IDLE, SERVE_I, SERVE_D.
REQ-005 In IDLE with only i_read high, SHALL go to SERVE_I on the next edge.
REQ-006 In IDLE with only d_read or d_write high, SHALL go to SERVE_D on the next edge.
REQ-007 In IDLE with both sides requesting, SHALL grant the side not granted last (round-robin via a last_grant register).
REQ-008 On each grant, SHALL update last_grant.
REQ-009 On each grant, SHALL latch address, direction and wdata (D side) into command registers.
REQ-010 pmem_read, pmem_write, pmem_address and pmem_wdata SHALL be driven only from the command registers, never combinationally from requester inputs.
REQ-011 SHALL drive pmem outputs low/zero in IDLE.
REQ-012 SHALL never assert pmem_read and pmem_write together.
REQ-013 In SERVE_x, SHALL hold the pmem command stable until pmem_resp is sampled high.
REQ-014 In the cycle pmem_resp is high, SHALL assert exactly the granted side's resp and return to IDLE on the next edge.
REQ-015 i_rdata and d_rdata SHALL equal pmem_rdata combinationally in all states; resp alone qualifies them.
REQ-016 SHALL never assert a resp outside the granted SERVE state; a pmem_resp arriving in IDLE SHALL be ignored.
REQ-017 Requesters deassert their request the cycle after resp.
REQ-018 IDLE SHALL therefore not re-sample a request during the cycle immediately after a completion: a one-cycle post-completion block flag suppresses grants.
REQ-019 A request line held high through completion SHALL not be re-granted until the block flag clears.
REQ-020 A d_read/d_write change during SERVE_D SHALL not alter the latched command.
REQ-021 Arbitration latency: grant to pmem command assertion SHALL be 1 cycle after the request is first seen in IDLE.
REQ-022 SHALL keep a 16-bit saturating wait counter per side that increments each cycle the side requests but is not granted.
REQ-023 Each wait counter SHALL clear on that side's grant; the counters are internal and debug-visible only.

Reset
REQ-024 On reset, SHALL enter IDLE.
REQ-025 On reset, SHALL clear command registers, wait counters and the block flag.
REQ-026 On reset, SHALL set last_grant = D, so the first tie goes to I.
REQ-027 During and after reset, SHALL hold all pmem outputs and resp outputs at 0.
REQ-028 Reset mid-transaction SHALL abort it: no resp to either side, pmem_read/pmem_write low on the next cycle.

Structure
REQ-029 The FSM state enum SHALL be defined in rv32i_types, alongside the LINE_WIDTH constant.
REQ-030 The grant_t (I/D) typedef SHALL be defined in rv32i_types.
REQ-031 There SHALL be no sub-modules; the FSM, command registers and counters are a single flat module.

Verification
REQ-032 I-only: i_read=1, i_address=0x0000_0060; memory model responds after 5 cycles with pattern A -> pmem_read=1, pmem_address=0x60 from cycle 1; i_resp pulse of 1 cycle with i_rdata=A; d_resp=0 throughout.
REQ-033 Simultaneous after reset: i_read=1 and d_write=1 (d_address=0x100) together -> I is served first; D is served after the block cycle with pmem_write=1 and pmem_wdata=d_wdata.
REQ-034 Back-to-back ties: both sides request continuously for 4 transactions -> grants alternate I, D, I, D; no two pmem commands are adjacent without an IDLE cycle.
REQ-035 Mid-write reset: assert reset 2 cycles into SERVE_D -> next cycle pmem_write=0, d_resp never asserts, state is IDLE.
REQ-036 Input churn: change d_address from 0x200 to 0x300 during SERVE_D -> pmem_address stays 0x200 until resp.
REQ-037 Spurious pmem_resp in IDLE -> no i_resp or d_resp.
